// File: rtl/logic_gate_unit.sv
// logic_gate_unit: registered N_IN-operand bitwise combiner with a selectable
// operation, valid/ready on both sides, a 2-entry output buffer, a wrapping
// transfer counter and a sticky reserved-mode error flag.
module logic_gate_unit #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N_IN  = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [2:0]            in_mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [2:0]            out_mode,
   output logic [CNT_W-1:0]      op_count,
   output logic                  err_flag
);

   localparam logic [2:0] ModeAnd  = 3'b000;
   localparam logic [2:0] ModeOr   = 3'b001;
   localparam logic [2:0] ModeXor  = 3'b010;
   localparam logic [2:0] ModeNand = 3'b011;
   localparam logic [2:0] ModeNor  = 3'b100;
   localparam logic [2:0] ModeXnor = 3'b101;
   localparam logic [2:0] ModePass = 3'b110;

   logic [WIDTH-1:0] mem_data_q [2];
   logic [2:0]       mem_mode_q [2];
   logic             wr_ptr_q, rd_ptr_q;
   logic [1:0]       count_q, count_d;
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;

   logic             push, pop;
   logic [WIDTH-1:0] red_and, red_or, red_xor;
   logic [WIDTH-1:0] result;

   // Ready/valid derive from registered occupancy only; no path from out_ready.
   assign in_ready  = (count_q < 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_data  = mem_data_q[rd_ptr_q];
   assign out_mode  = mem_mode_q[rd_ptr_q];
   assign op_count  = cnt_q;
   assign err_flag  = err_q;

   // Reduce all operands, then pick the requested operation.
   always_comb begin
      red_and = '1;
      red_or  = '0;
      red_xor = '0;
      for (int k = 0; k < N_IN; k++) begin
         red_and = red_and & in_data[k*WIDTH +: WIDTH];
         red_or  = red_or  | in_data[k*WIDTH +: WIDTH];
         red_xor = red_xor ^ in_data[k*WIDTH +: WIDTH];
      end
      case (in_mode)
         ModeAnd:  result = red_and;
         ModeOr:   result = red_or;
         ModeXor:  result = red_xor;
         ModeNand: result = ~red_and;
         ModeNor:  result = ~red_or;
         ModeXnor: result = ~red_xor;
         ModePass: result = in_data[WIDTH-1:0];
         default:  result = '0;  // reserved mode emits zeros
      endcase
   end

   // Occupancy next state; simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (pop && !push) begin
         count_d = count_q - 2'd1;
      end
   end

   // Buffer storage, pointers, occupancy, transfer counter and error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_data_q[0] <= '0;
         mem_data_q[1] <= '0;
         mem_mode_q[0] <= '0;
         mem_mode_q[1] <= '0;
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         count_q       <= 2'd0;
         cnt_q         <= '0;
         err_q         <= 1'b0;
      end else begin
         count_q <= count_d;
         if (push) begin
            mem_data_q[wr_ptr_q] <= result;
            mem_mode_q[wr_ptr_q] <= in_mode;
            wr_ptr_q             <= ~wr_ptr_q;
            if (in_mode == 3'b111) begin
               err_q <= 1'b1;
            end
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
            cnt_q    <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Bench for logic_gate_unit: scoreboard monitor plus per-scenario tasks.
module tb_logic_gate_unit;

   localparam int WIDTH = 8;
   localparam int N_IN  = 4;
   localparam int CNT_W = 4;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic [N_IN*WIDTH-1:0] in_data = '0;
   logic [2:0]            in_mode = '0;
   logic                  out_valid;
   logic                  out_ready = 1'b0;
   logic [WIDTH-1:0]      out_data;
   logic [2:0]            out_mode;
   logic [CNT_W-1:0]      op_count;
   logic                  err_flag;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [2:0]       mode;
   } exp_t;

   exp_t             sb [$];
   logic [CNT_W-1:0] exp_count = '0;

   logic_gate_unit #(
      .WIDTH(WIDTH),
      .N_IN (N_IN),
      .CNT_W(CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_mode  (in_mode),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_mode (out_mode),
      .op_count (op_count),
      .err_flag (err_flag)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] model(input logic [N_IN*WIDTH-1:0] d,
                                              input logic [2:0] m);
      logic [WIDTH-1:0] a, o, x, r;
      a = '1;
      o = '0;
      x = '0;
      for (int k = 0; k < N_IN; k++) begin
         a = a & d[k*WIDTH +: WIDTH];
         o = o | d[k*WIDTH +: WIDTH];
         x = x ^ d[k*WIDTH +: WIDTH];
      end
      case (m)
         3'd0:    r = a;
         3'd1:    r = o;
         3'd2:    r = x;
         3'd3:    r = ~a;
         3'd4:    r = ~o;
         3'd5:    r = ~x;
         3'd6:    r = d[WIDTH-1:0];
         default: r = '0;
      endcase
      return r;
   endfunction

   // Scoreboard monitor: inputs change just after posedge, so negedge sees
   // exactly what the next rising edge will act on.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sb.delete();
         exp_count = '0;
      end else begin
         total++;
         if (op_count !== exp_count) begin
            bad++;
            $display("FAIL op_count: got %0d want %0d", op_count, exp_count);
         end
         if (out_valid && out_ready) begin
            exp_count = exp_count + 1'b1;
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_output: got data=%h mode=%0d, none expected",
                        out_data, out_mode);
            end else begin
               e = sb.pop_front();
               if (out_data !== e.data || out_mode !== e.mode) begin
                  bad++;
                  $display("FAIL sb_order: got data=%h mode=%0d want data=%h mode=%0d",
                           out_data, out_mode, e.data, e.mode);
               end
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back({model(in_data, in_mode), in_mode});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [N_IN*WIDTH-1:0] d, input logic [2:0] m);
      in_valid = v;
      in_data  = d;
      in_mode  = m;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00 || out_mode !== 3'd0 ||
          op_count !== 4'd0 || err_flag !== 1'b0) begin
         bad++;
         $display("FAIL reset_values: got ov=%b ir=%b od=%h om=%0d cnt=%0d err=%b want 0 1 00 0 0 0",
                  out_valid, in_ready, out_data, out_mode, op_count, err_flag);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_truth();
      logic [7:0] tt [0:6];
      tt = '{8'h00, 8'hFF, 8'hA5, 8'hFF, 8'h00, 8'h5A, 8'hA5};
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, {8'hF0, 8'h0F, 8'hFF, 8'hA5}, 3'(i));
         tick();
         drive(1'b0, '0, 3'd0);
         total++;
         if (out_valid !== 1'b1 || out_data !== tt[i] || out_mode !== 3'(i)) begin
            bad++;
            $display("FAIL truth_mode%0d: got ov=%b data=%h mode=%0d want ov=1 data=%h mode=%0d",
                     i, out_valid, out_data, out_mode, tt[i], i);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0]      t1, t2, t3;
      logic [CNT_W-1:0] base;
      t1 = $urandom;
      t2 = $urandom;
      t3 = $urandom;
      out_ready = 1'b0;
      drive(1'b1, t1, 3'd2);
      tick();
      drive(1'b1, t2, 3'd1);
      tick();
      drive(1'b1, t3, 3'd5);
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL bp_full: got in_ready=%b want 0", in_ready);
      end
      tick();
      total++;
      if (in_ready !== 1'b0 || out_data !== model(t1, 3'd2) || out_mode !== 3'd2) begin
         bad++;
         $display("FAIL bp_hold: got ir=%b data=%h mode=%0d want ir=0 data=%h mode=2",
                  in_ready, out_data, out_mode, model(t1, 3'd2));
      end
      base = op_count;
      out_ready = 1'b1;
      tick();
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_reopen: got in_ready=%b want 1", in_ready);
      end
      tick();
      drive(1'b0, '0, 3'd0);
      total++;
      if (out_valid !== 1'b1 || out_data !== model(t3, 3'd5) || out_mode !== 3'd5) begin
         bad++;
         $display("FAIL bp_third: got ov=%b data=%h mode=%0d want ov=1 data=%h mode=5",
                  out_valid, out_data, out_mode, model(t3, 3'd5));
      end
      tick();
      total++;
      if (op_count !== CNT_W'(base + 3) || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_count: got cnt=%0d ov=%b want cnt=%0d ov=0",
                  op_count, out_valid, CNT_W'(base + 3));
      end
   endtask

   task automatic test_back_to_back();
      logic [CNT_W-1:0] base;
      int               drops;
      out_ready = 1'b0;
      drive(1'b1, $urandom, 3'($urandom_range(6)));
      tick();
      out_ready = 1'b1;
      base  = op_count;
      drops = 0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, $urandom, 3'($urandom_range(6)));
         tick();
         if (in_ready !== 1'b1 || out_valid !== 1'b1) drops++;
      end
      total++;
      if (drops != 0) begin
         bad++;
         $display("FAIL b2b_ready: got %0d cycles with ir/ov low want 0", drops);
      end
      total++;
      if (op_count !== CNT_W'(base + 20)) begin
         bad++;
         $display("FAIL b2b_count: got %0d want %0d", op_count, CNT_W'(base + 20));
      end
      drive(1'b0, '0, 3'd0);
      tick();
   endtask

   task automatic test_reserved();
      out_ready = 1'b1;
      total++;
      if (err_flag !== 1'b0) begin
         bad++;
         $display("FAIL rsv_pre: got err=%b want 0", err_flag);
      end
      drive(1'b1, $urandom, 3'd7);
      tick();
      drive(1'b0, '0, 3'd0);
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h00 || out_mode !== 3'd7 || err_flag !== 1'b1) begin
         bad++;
         $display("FAIL rsv_out: got ov=%b data=%h mode=%0d err=%b want 1 00 7 1",
                  out_valid, out_data, out_mode, err_flag);
      end
      tick();
      drive(1'b1, $urandom, 3'd1);
      tick();
      drive(1'b0, '0, 3'd0);
      tick();
      total++;
      if (err_flag !== 1'b1) begin
         bad++;
         $display("FAIL rsv_sticky: got err=%b want 1", err_flag);
      end
   endtask

   task automatic test_wrap();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, $urandom, 3'($urandom_range(6)));
         tick();
      end
      drive(1'b0, '0, 3'd0);
      tick();
      total++;
      if (op_count !== 4'd1) begin
         bad++;
         $display("FAIL wrap: got op_count=%0d want 1", op_count);
      end
   endtask

   task automatic test_reset_midstream();
      logic [31:0] d;
      out_ready = 1'b0;
      drive(1'b1, $urandom, 3'd7);
      tick();
      drive(1'b1, $urandom, 3'd2);
      tick();
      drive(1'b0, '0, 3'd0);
      rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== 4'd0 || err_flag !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid: got ov=%b ir=%b cnt=%0d err=%b want 0 1 0 0",
                  out_valid, in_ready, op_count, err_flag);
      end
      tick();
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_quiet%0d: got out_valid=%b want 0", i, out_valid);
         end
      end
      d = $urandom;
      drive(1'b1, d, 3'd0);
      tick();
      drive(1'b0, '0, 3'd0);
      total++;
      if (out_valid !== 1'b1 || out_data !== model(d, 3'd0)) begin
         bad++;
         $display("FAIL rst_resume: got ov=%b data=%h want ov=1 data=%h",
                  out_valid, out_data, model(d, 3'd0));
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_truth();
      test_backpressure();
      test_back_to_back();
      test_reserved();
      test_wrap();
      test_reset_midstream();
      tick();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: got %0d pending results want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
